// File: rtl/flaf_trig_arg_gen_pkg.sv
// ---------------------------------------------------------------------------
// flaf_trig_arg_gen_pkg
// Shared constants and types for the functional-link trigonometric argument
// generator.
//   - Q5.12 angle constants (PI, PI/2, 2*PI rounded down), both at the
//     17-bit port width and at the 18-bit internal accumulator width
//   - input clip limits (+/-1.0 in Q4.12)
//   - FSM state encoding
// ---------------------------------------------------------------------------
package flaf_trig_arg_gen_pkg;

  localparam int X_W     = 16;  // Q4.12 sample width
  localparam int THETA_W = 17;  // Q5.12 angle width
  localparam int ACC_W   = 18;  // internal add/sub width, holds +/-2*PI
  localparam int IDX_W   = 4;   // harmonic index width

  localparam logic signed [THETA_W-1:0] PI   = 17'sh03244;
  localparam logic signed [THETA_W-1:0] PIB2 = 17'sh01922;
  localparam logic signed [THETA_W-1:0] PIM2 = 17'sh06487;

  localparam logic signed [ACC_W-1:0] PI_ACC   = 18'sh03244;
  localparam logic signed [ACC_W-1:0] PIM2_ACC = 18'sh06487;

  localparam logic signed [X_W-1:0] X_MAX = 16'sh1000;
  localparam logic signed [X_W-1:0] X_MIN = 16'shF000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Saturate a Q4.12 sample to [-1.0, +1.0].
  function automatic logic signed [X_W-1:0] clip_x(input logic signed [X_W-1:0] x);
    if (x > X_MAX)
      return X_MAX;
    else if (x < X_MIN)
      return X_MIN;
    else
      return x;
  endfunction

endpackage

// File: rtl/DelayUnit.sv
// ---------------------------------------------------------------------------
// DelayUnit
// Fixed-depth register delay line with synchronous active-high clear.
// DEPTH = 0 is a plain wire.
// Ports:
//   clk   in          clock
//   reset in          synchronous active-high clear of every stage
//   din   in  WIDTH   data entering the line
//   dout  out WIDTH   data delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module DelayUnit #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe_reg [DEPTH];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++)
            pipe_reg[i] <= '0;
        end else begin
          pipe_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++)
            pipe_reg[i] <= pipe_reg[i-1];
        end
      end

      assign dout = pipe_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/flaf_trig_arg_gen_wrap_add.sv
// ---------------------------------------------------------------------------
// flaf_wrap_add
// Combinational Q5.12 add/sub with a single +/-2*PI correction so the result
// lands back in [-PI, PI]. Both operands must already lie in [-PI, PI], so
// the 18-bit sum stays within +/-2*PI and one correction is always enough.
// Ports:
//   a    in  17  signed Q5.12 operand
//   b    in  17  signed Q5.12 operand
//   sub  in  1   1: a - b, 0: a + b
//   y    out 17  wrapped signed Q5.12 result
// ---------------------------------------------------------------------------
module flaf_wrap_add
  import flaf_trig_arg_gen_pkg::*;
(
  input  logic signed [THETA_W-1:0] a,
  input  logic signed [THETA_W-1:0] b,
  input  logic                      sub,
  output logic signed [THETA_W-1:0] y
);

  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] wrapped;

  always_comb begin
    a_ext   = {a[THETA_W-1], a};
    b_ext   = {b[THETA_W-1], b};
    sum     = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    wrapped = sum;
    if (sum > PI_ACC)
      wrapped = sum - PIM2_ACC;
    else if (sum < -PI_ACC)
      wrapped = sum + PIM2_ACC;
    y = wrapped[THETA_W-1:0];
  end

endmodule

// File: rtl/flaf_trig_arg_gen.sv
// ---------------------------------------------------------------------------
// flaf_trig_arg_gen
// Argument generator for the functional-link trigonometric expansion. Takes
// one Q4.12 sample per handshake and emits a gap-free burst of Q5.12 angles
// k*pi*x (cos term) and k*pi*x - pi/2 (sin term) for k = 1..ORDER, wrapped to
// [-pi, pi], one per cycle, for the downstream cosine approximator. A tag
// delayed by LAT cycles labels each word the approximator returns.
//
// Build option FLAF_SIN_ARG_EN:
//   defined   -> cos_k, sin_k pairs, 2*ORDER terms per burst
//   undefined -> cos terms only, ORDER terms per burst, tag_sin tied to 0
//
// Ports:
//   clk        in   1   clock
//   reset      in   1   synchronous active-high reset
//   x_in       in   16  signed sample, Q4.12
//   in_valid   in   1   x_in valid
//   in_ready   out  1   block can accept a sample (IDLE only)
//   theta_out  out  17  signed angle, Q5.12
//   theta_vld  out  1   theta_out valid
//   last       out  1   final term of the burst
//   tag_idx    out  4   harmonic k of the word leaving the cosine stage
//   tag_sin    out  1   that word is a sine term
//   tag_vld    out  1   cosine stage output valid
//   tag_last   out  1   last, delayed by LAT
// ---------------------------------------------------------------------------
module flaf_trig_arg_gen
  import flaf_trig_arg_gen_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int LAT   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [X_W-1:0]     x_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [THETA_W-1:0] theta_out,
  output logic               theta_vld,
  output logic               last,
  output logic [IDX_W-1:0]   tag_idx,
  output logic               tag_sin,
  output logic               tag_vld,
  output logic               tag_last
);

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(ORDER);

  state_t state_reg, state_next;

  logic signed [X_W-1:0]     x_reg;
  logic signed [THETA_W-1:0] step_reg;
  logic signed [THETA_W-1:0] acc_reg;   // holds acc_{k-1} while emitting harmonic k
  logic [IDX_W-1:0]          k_reg;
  logic                      sin_reg;   // current term is the sine half of the pair

  logic signed [X_W-1:0]     x_clip;
  logic signed [THETA_W-1:0] x_ext;
  logic signed [33:0]        prod;
  logic signed [THETA_W-1:0] step_next;
  logic signed [THETA_W-1:0] acc_k;
  logic signed [THETA_W-1:0] sin_theta;
  logic                      emit;
  logic                      last_term;
  logic                      advance;   // accumulator moves to the next harmonic

  // Step = floor(x_clip * PI / 4096); with |x_clip| <= 1.0 this is within +/-PI.
  always_comb begin
    x_clip    = clip_x(x_reg);
    x_ext     = {x_clip[X_W-1], x_clip};
    prod      = 34'(x_ext) * 34'(PI);
    step_next = prod[12+THETA_W-1:12];
  end

  // acc_k is produced combinationally from acc_{k-1} so the first term can
  // appear the cycle after MUL without a separate pre-load stage.
  flaf_wrap_add u_acc_wrap (
    .a   (acc_reg),
    .b   (step_reg),
    .sub (1'b0),
    .y   (acc_k)
  );

`ifdef FLAF_SIN_ARG_EN
  flaf_wrap_add u_sin_wrap (
    .a   (acc_k),
    .b   (PIB2),
    .sub (1'b1),
    .y   (sin_theta)
  );
  assign advance   = sin_reg;
  assign last_term = sin_reg && (k_reg == K_LAST);
`else
  assign sin_theta = acc_k;
  assign advance   = 1'b1;
  assign last_term = (k_reg == K_LAST);
`endif

  assign emit = (state_reg == EMIT);

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    theta_vld  = 1'b0;
    theta_out  = '0;
    last       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = MUL;
      end
      MUL: begin
        state_next = EMIT;
      end
      EMIT: begin
        theta_vld = 1'b1;
        theta_out = sin_reg ? sin_theta : acc_k;
        last      = last_term;
        if (last_term)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      step_reg  <= '0;
      acc_reg   <= '0;
      k_reg     <= '0;
      sin_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        IDLE: begin
          if (in_valid)
            x_reg <= x_in;
        end
        MUL: begin
          step_reg <= step_next;
          acc_reg  <= '0;
          k_reg    <= IDX_W'(1);
          sin_reg  <= 1'b0;
        end
        EMIT: begin
          if (advance) begin
            acc_reg <= acc_k;
            k_reg   <= k_reg + 1'b1;
            sin_reg <= 1'b0;
          end else begin
            sin_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag path: aligns each term's label with the cosine stage's output.
  logic [IDX_W-1:0] idx_src;
  assign idx_src = emit ? k_reg : '0;

  DelayUnit #(.WIDTH(IDX_W), .DEPTH(LAT)) u_dly_idx (
    .clk   (clk),
    .reset (reset),
    .din   (idx_src),
    .dout  (tag_idx)
  );

  DelayUnit #(.WIDTH(1), .DEPTH(LAT)) u_dly_vld (
    .clk   (clk),
    .reset (reset),
    .din   (theta_vld),
    .dout  (tag_vld)
  );

  DelayUnit #(.WIDTH(1), .DEPTH(LAT)) u_dly_last (
    .clk   (clk),
    .reset (reset),
    .din   (last),
    .dout  (tag_last)
  );

`ifdef FLAF_SIN_ARG_EN
  logic sin_src;
  assign sin_src = emit && sin_reg;

  DelayUnit #(.WIDTH(1), .DEPTH(LAT)) u_dly_sin (
    .clk   (clk),
    .reset (reset),
    .din   (sin_src),
    .dout  (tag_sin)
  );
`else
  assign tag_sin = 1'b0;
`endif

endmodule

// File: tb/tb_flaf_trig_arg_gen.sv
// ---------------------------------------------------------------------------
// tb_flaf_trig_arg_gen
// Directed bench for flaf_trig_arg_gen (ORDER=3, LAT=2). Expected angles are
// hand-computed Q5.12 values; the sequence adapts to FLAF_SIN_ARG_EN.
// ---------------------------------------------------------------------------
module tb_flaf_trig_arg_gen;

  localparam int ORDER = 3;
  localparam int LAT   = 2;
`ifdef FLAF_SIN_ARG_EN
  localparam int NT = 2 * ORDER;
`else
  localparam int NT = ORDER;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] x_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] theta_out;
  logic        theta_vld;
  logic        last;
  logic [3:0]  tag_idx;
  logic        tag_sin;
  logic        tag_vld;
  logic        tag_last;

  int n_checks = 0;
  int n_pass   = 0;

  logic [16:0] exp_theta [6];

  always #5 clk = ~clk;

  flaf_trig_arg_gen #(.ORDER(ORDER), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .theta_out (theta_out),
    .theta_vld (theta_vld),
    .last      (last),
    .tag_idx   (tag_idx),
    .tag_sin   (tag_sin),
    .tag_vld   (tag_vld),
    .tag_last  (tag_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  // One sample through a full burst; checks theta stream, handshake and tags.
  task automatic burst(input logic [15:0] x);
    int jt;
    @(negedge clk);
    x_in = x;
    in_valid = 1'b1;
    check("accept_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("mul_ready", 32'(in_ready), 32'd0);
    check("mul_vld", 32'(theta_vld), 32'd0);
    for (int c = 0; c < NT + LAT; c++) begin
      @(negedge clk);
      if (c < NT) begin
        check("theta_vld", 32'(theta_vld), 32'd1);
        check("theta", 32'(theta_out), 32'(exp_theta[c]));
        check("last", 32'(last), (c == NT - 1) ? 32'd1 : 32'd0);
        check("busy_ready", 32'(in_ready), 32'd0);
      end else begin
        check("idle_vld", 32'(theta_vld), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
      end
      jt = c - LAT;
      if (jt >= 0 && jt < NT) begin
        check("tag_vld", 32'(tag_vld), 32'd1);
`ifdef FLAF_SIN_ARG_EN
        check("tag_idx", 32'(tag_idx), 32'(jt / 2 + 1));
        check("tag_sin", 32'(tag_sin), 32'(jt % 2));
`else
        check("tag_idx", 32'(tag_idx), 32'(jt + 1));
        check("tag_sin", 32'(tag_sin), 32'd0);
`endif
        check("tag_last", 32'(tag_last), (jt == NT - 1) ? 32'd1 : 32'd0);
      end else begin
        check("tag_idle", 32'(tag_vld), 32'd0);
      end
    end
    $display("burst x=0x%04h done, %0d/%0d checks so far", x, n_pass, n_checks);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_vld", 32'(theta_vld), 32'd0);
    check("rst_theta", 32'(theta_out), 32'd0);
    check("rst_tag_vld", 32'(tag_vld), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // x = +1.0: wrap path every harmonic
`ifdef FLAF_SIN_ARG_EN
    exp_theta = '{17'h03244, 17'h01922, 17'h00001, 17'h1E6DF, 17'h1CDBE, 17'h01923};
`else
    exp_theta = '{17'h03244, 17'h00001, 17'h1CDBE, 17'h0, 17'h0, 17'h0};
`endif
    burst(16'h1000);

    // x = 0
`ifdef FLAF_SIN_ARG_EN
    exp_theta = '{17'h00000, 17'h1E6DE, 17'h00000, 17'h1E6DE, 17'h00000, 17'h1E6DE};
`else
    exp_theta = '{17'h00000, 17'h00000, 17'h00000, 17'h0, 17'h0, 17'h0};
`endif
    burst(16'h0000);

    // Positive clip: same as +1.0
`ifdef FLAF_SIN_ARG_EN
    exp_theta = '{17'h03244, 17'h01922, 17'h00001, 17'h1E6DF, 17'h1CDBE, 17'h01923};
`else
    exp_theta = '{17'h03244, 17'h00001, 17'h1CDBE, 17'h0, 17'h0, 17'h0};
`endif
    burst(16'h7FFF);

    // Negative clip to -1.0
`ifdef FLAF_SIN_ARG_EN
    exp_theta = '{17'h1CDBC, 17'h01921, 17'h1FFFF, 17'h1E6DD, 17'h03242, 17'h01920};
`else
    exp_theta = '{17'h1CDBC, 17'h1FFFF, 17'h03242, 17'h0, 17'h0, 17'h0};
`endif
    burst(16'h8000);

    // x = -0.5: sin_1 sits exactly on -PI and stays unwrapped
`ifdef FLAF_SIN_ARG_EN
    exp_theta = '{17'h1E6DE, 17'h1CDBC, 17'h1CDBC, 17'h01921, 17'h01921, 17'h1FFFF};
`else
    exp_theta = '{17'h1E6DE, 17'h1CDBC, 17'h01921, 17'h0, 17'h0, 17'h0};
`endif
    burst(16'hF800);

    // Reset in the third EMIT cycle aborts the burst
    @(negedge clk);
    x_in = 16'h1000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_vld", 32'(theta_vld), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_vld", 32'(theta_vld), 32'd0);
    check("abort_tag_vld", 32'(tag_vld), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_theta", 32'(theta_out), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      check("after_abort_vld", 32'(theta_vld), 32'd0);
      check("after_abort_tag", 32'(tag_vld), 32'd0);
    end
    $display("reset abort done, %0d/%0d checks so far", n_pass, n_checks);

    // Clean burst after the abort
`ifdef FLAF_SIN_ARG_EN
    exp_theta = '{17'h00000, 17'h1E6DE, 17'h00000, 17'h1E6DE, 17'h00000, 17'h1E6DE};
`else
    exp_theta = '{17'h00000, 17'h00000, 17'h00000, 17'h0, 17'h0, 17'h0};
`endif
    burst(16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
